dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one bus transaction per MEM-stage load/store, lane/strobe generation, read-word buffer.
// Latency: request issued combinationally in the access cycle; read word valid the cycle after data_data_ok.
// Backpressure: stall_o holds IF..MEM until data_data_ok; a flushed in-flight transaction drains in CANCEL without stalling.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   mem_valid/re/we/size/addr/wdata MEM-stage access request (held stable while stall_o=1)
//   flush, mem_adv                 MEM-stage flush, MEM/WB capture strobe
//   stall_o, mem_data_o            pipeline freeze, buffered raw read word
//   adel_o, ades_o                 load/store address error (combinational)
//   data_*                         SRAM-like data bus (req/addr_ok/data_ok handshake)
module dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        mem_adv,
    output logic        stall_o,
    output logic [31:0] mem_data_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_kill;
    logic [31:0] r_rbuf;

    logic        w_acc;
    logic        w_misal;
    logic        w_go;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic        w_req;
    logic        w_stall;

    assign w_acc = mem_valid & (mem_re | mem_we) & ~flush;

    // Size 11 is treated as a word access.
    always_comb begin
        w_misal = 1'b0;
        case (mem_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = mem_addr[0];
            default: w_misal = |mem_addr[1:0];
        endcase
    end

    assign w_go = w_acc & ~w_misal;

    // Store data is replicated across all lanes so the strobes alone select the bytes.
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = mem_wdata;
        case (mem_size)
            2'b00: begin
                w_strb  = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = mem_wdata;
            end
        endcase
        if (!mem_we) begin
            w_strb = 4'b0000;
        end
    end

    // In CANCEL a new access must wait for the drained transaction, so it stalls without requesting.
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:   begin w_req = w_go; w_stall = w_go; end
            S_REQ:    begin w_req = 1'b1; w_stall = 1'b1; end
            S_WAIT:   begin w_req = 1'b0; w_stall = 1'b1; end
            S_DONE:   begin w_req = 1'b0; w_stall = 1'b0; end
            S_CANCEL: begin w_req = 1'b0; w_stall = w_go; end
            default:  begin w_req = 1'b0; w_stall = 1'b0; end
        endcase
    end

    // Every output, including the combinational ones, is forced low while reset is held.
    assign stall_o    = rst & w_stall;
    assign data_req   = rst & w_req;
    assign adel_o     = rst & w_acc & w_misal & mem_re;
    assign ades_o     = rst & w_acc & w_misal & mem_we;
    assign data_wr    = rst & mem_we;
    assign data_size  = rst ? mem_size : 2'b00;
    assign data_addr  = rst ? mem_addr : 32'd0;
    assign data_wstrb = rst ? w_strb : 4'b0000;
    assign data_wdata = rst ? w_wdata : 32'd0;
    assign mem_data_o = rst ? r_rbuf : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
            r_rbuf  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_go) begin
                        r_state <= data_addr_ok ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    // The request cannot be withdrawn, so a flush here is remembered until accept.
                    r_kill <= r_kill | flush;
                    if (data_addr_ok) begin
                        r_state <= (flush | r_kill) ? S_CANCEL : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                            r_kill  <= 1'b0;
                        end else begin
                            r_rbuf  <= data_rdata;
                            r_state <= S_DONE;
                        end
                    end else if (flush) begin
                        r_state <= S_CANCEL;
                    end
                end
                S_DONE: begin
                    if (mem_adv | flush) begin
                        r_state <= S_IDLE;
                        r_kill  <= 1'b0;
                    end
                end
                S_CANCEL: begin
                    if (data_data_ok) begin
                        r_state <= S_IDLE;
                        r_kill  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_re, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        flush, mem_adv;
    logic        stall_o;
    logic [31:0] mem_data_o;
    logic        adel_o, ades_o;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference copy of the buffered read word.
    logic [31:0] exp_rbuf = 32'd0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .mem_adv      (mem_adv),
        .stall_o      (stall_o),
        .mem_data_o   (mem_data_o),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference model: alignment and lane rules from plain arithmetic.
    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        int bytes;
        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        return (a % bytes) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
        int bytes;
        int mask;
        if (!we) return 4'd0;
        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mask  = (1 << bytes) - 1;
        return 4'((mask << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One aligned transaction: accept after a_dly cycles, completion d_dly cycles later,
    // then 'hold' extra DONE cycles before mem_adv.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input int a_dly, input int d_dly,
                           input logic [31:0] rd, input logic [3:0] e_strb,
                           input logic [31:0] e_wd, input int hold);
        mem_valid = 1'b1; mem_re = ~we; mem_we = we; mem_size = sz;
        mem_addr = addr; mem_wdata = wd; flush = 1'b0; mem_adv = 1'b0;
        for (int c = 0; c <= a_dly + d_dly; c++) begin
            data_addr_ok = (c == a_dly);
            // Spurious data_ok before acceptance must be ignored.
            data_data_ok = (c == a_dly + d_dly) || (c < a_dly && $urandom_range(0, 1) == 1);
            data_rdata   = (c == a_dly + d_dly) ? rd : $urandom;
            @(negedge clk);
            chk("txn_stall", 32'(stall_o), 32'd1);
            chk("txn_req", 32'(data_req), 32'(c <= a_dly));
            chk("txn_rbuf_hold", mem_data_o, exp_rbuf);
            if (c <= a_dly) begin
                chk("txn_addr", data_addr, addr);
                chk("txn_wr", 32'(data_wr), 32'(we));
                chk("txn_size", 32'(data_size), 32'(sz));
                chk("txn_wstrb", 32'(data_wstrb), 32'(e_strb));
                chk("txn_wdata", data_wdata, e_wd);
            end
            next_cycle();
        end
        exp_rbuf = rd;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            mem_adv = (h == hold);
            @(negedge clk);
            chk("done_stall", 32'(stall_o), 32'd0);
            chk("done_req", 32'(data_req), 32'd0);
            chk("done_data", mem_data_o, exp_rbuf);
            next_cycle();
        end
        mem_adv = 1'b0;
    endtask

    task automatic set_access(input logic we, input logic [1:0] sz, input logic [31:0] addr);
        mem_valid = 1'b1; mem_re = ~we; mem_we = we; mem_size = sz; mem_addr = addr;
    endtask

    initial begin
        logic        r_we;
        logic [1:0]  r_sz;
        logic [31:0] r_addr, r_wd, r_rd, old;

        // Reset with an active store presented: every output must read 0.
        rst = 1'b0; flush = 1'b0; mem_adv = 1'b0;
        mem_valid = 1'b1; mem_re = 1'b0; mem_we = 1'b1; mem_size = 2'd2;
        mem_addr = 32'h0000_1000; mem_wdata = 32'hFFFF_FFFF;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #3;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wr", 32'(data_wr), 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall_o), 32'd0);
        chk("post_rst_data", mem_data_o, 32'd0);
        next_cycle();

        // Aligned load: accept at 0, complete at 2.
        run_txn(1'b0, 2'd2, 32'h0000_1000, 32'd0, 0, 2, 32'hDEAD_BEEF, 4'b0000, 32'd0, 0);

        // Store lanes.
        run_txn(1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5, 0, 1, 32'h1111_0000, 4'b1000, 32'hA5A5_A5A5, 0);
        run_txn(1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, 1, 1, 32'h2222_0000, 4'b1100, 32'h1234_1234, 0);
        run_txn(1'b1, 2'd2, 32'h0000_2004, 32'hCAFE_F00D, 0, 1, 32'h3333_0000, 4'b1111, 32'hCAFE_F00D, 0);

        // Address errors: no request, no stall, controller stays idle.
        set_access(1'b0, 2'd1, 32'h0000_1001);
        @(negedge clk);
        chk("adel", 32'(adel_o), 32'd1);
        chk("adel_ades", 32'(ades_o), 32'd0);
        chk("adel_req", 32'(data_req), 32'd0);
        chk("adel_stall", 32'(stall_o), 32'd0);
        next_cycle();
        set_access(1'b1, 2'd2, 32'h0000_1002);
        @(negedge clk);
        chk("ades", 32'(ades_o), 32'd1);
        chk("ades_adel", 32'(adel_o), 32'd0);
        chk("ades_req", 32'(data_req), 32'd0);
        chk("ades_stall", 32'(stall_o), 32'd0);
        next_cycle();

        // Delayed accept: request held steady for 3 cycles.
        run_txn(1'b1, 2'd1, 32'h0000_3000, 32'h0000_BEEF, 3, 2, 32'h4444_0000, 4'b0011, 32'hBEEF_BEEF, 1);

        // Flush during WAIT: drain, stall drops next cycle, late data discarded.
        old = exp_rbuf;
        set_access(1'b0, 2'd2, 32'h0000_4000);
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("wflush_stall_wait", 32'(stall_o), 32'd1);
        next_cycle();
        flush = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        chk("cancel_stall", 32'(stall_o), 32'd0);
        chk("cancel_req", 32'(data_req), 32'd0);
        next_cycle();
        set_access(1'b0, 2'd2, 32'h0000_4004);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("cancel_newacc_stall", 32'(stall_o), 32'd1);
        chk("cancel_newacc_req", 32'(data_req), 32'd0);
        chk("cancel_rbuf", mem_data_o, old);
        next_cycle();
        data_data_ok = 1'b0;
        run_txn(1'b0, 2'd2, 32'h0000_4004, 32'd0, 0, 1, 32'h5555_AAAA, 4'b0000, 32'd0, 0);

        // Flush during REQ: request held until accept, then drained.
        set_access(1'b0, 2'd2, 32'h0000_5000);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("rflush_req", 32'(data_req), 32'd1);
        next_cycle();
        flush = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        chk("rflush_req_held", 32'(data_req), 32'd1);
        chk("rflush_addr_held", data_addr, 32'h0000_5000);
        next_cycle();
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rflush_req_accept", 32'(data_req), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rflush_cancel_req", 32'(data_req), 32'd0);
        chk("rflush_cancel_stall", 32'(stall_o), 32'd0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD;
        next_cycle();
        data_data_ok = 1'b0;
        run_txn(1'b1, 2'd0, 32'h0000_5001, 32'h0000_0077, 0, 1, 32'h6666_0000, 4'b0010, 32'h7777_7777, 0);

        // Reset in WAIT.
        set_access(1'b0, 2'd2, 32'h0000_6000);
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_req", 32'(data_req), 32'd0);
        chk("midrst_data", mem_data_o, 32'd0);
        next_cycle();
        rst = 1'b1; mem_valid = 1'b0;
        exp_rbuf = 32'd0;
        @(negedge clk);
        chk("midrst_post_stall", 32'(stall_o), 32'd0);
        chk("midrst_post_data", mem_data_o, 32'd0);
        next_cycle();
        run_txn(1'b0, 2'd0, 32'h0000_6002, 32'd0, 0, 1, 32'h0102_0304, 4'b0000, 32'd0, 0);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_sz   = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            r_wd   = $urandom;
            r_rd   = $urandom;
            if (m_misal(r_sz, r_addr)) begin
                set_access(r_we, r_sz, r_addr);
                mem_wdata = r_wd;
                @(negedge clk);
                chk("rnd_adel", 32'(adel_o), 32'(!r_we));
                chk("rnd_ades", 32'(ades_o), 32'(r_we));
                chk("rnd_err_req", 32'(data_req), 32'd0);
                chk("rnd_err_stall", 32'(stall_o), 32'd0);
                next_cycle();
            end else begin
                run_txn(r_we, r_sz, r_addr, r_wd, int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 3)), r_rd, m_strb(r_we, r_sz, r_addr),
                        m_wd(r_sz, r_wd), int'($urandom_range(0, 2)));
            end
        end

        mem_valid = 1'b0;
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
